// File: rtl/branch_entry_loader_if.sv
// branch_entry_loader_if: install request, ALU arbitration input and config write port of the branch entry loader
interface branch_entry_loader_if #(
  parameter int PC_WIDTH = 10,
  parameter int D_OPERAND_WIDTH = 12,
  parameter int WORD_WIDTH = 36,
  parameter int COND_WIDTH = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int SLOT_WIDTH = 2
);
  logic req_valid;
  logic req_ready;
  logic [THREAD_ADDR_WIDTH-1:0] req_thread;
  logic [SLOT_WIDTH-1:0] req_slot;
  logic [PC_WIDTH-1:0] req_origin;
  logic [PC_WIDTH-1:0] req_destination;
  logic [COND_WIDTH-1:0] req_condition;
  logic req_prediction;
  logic req_pred_enable;
  logic alu_write_valid;
  logic wr_valid;
  logic [D_OPERAND_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;
  logic [THREAD_ADDR_WIDTH-1:0] current_thread;
  logic busy;
  logic done;
  logic error;
  modport master(
    output req_valid, req_thread, req_slot, req_origin, req_destination, req_condition,
           req_prediction, req_pred_enable, alu_write_valid,
    input req_ready, wr_valid, wr_addr, wr_data, current_thread, busy, done, error
  );
  modport slave(
    input req_valid, req_thread, req_slot, req_origin, req_destination, req_condition,
          req_prediction, req_pred_enable, alu_write_valid,
    output req_ready, wr_valid, wr_addr, wr_data, current_thread, busy, done, error
  );
endinterface

// File: rtl/branch_entry_loader.sv
// branch_entry_loader: writes one branch-folding entry field by field into the config port
// during the target thread's write-stage slots, yielding to the ALU.
module branch_entry_loader #(
  parameter int PC_WIDTH = 10,
  parameter int D_OPERAND_WIDTH = 12,
  parameter int WORD_WIDTH = 36,
  parameter int COND_WIDTH = 8,
  parameter int THREAD_COUNT = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int INITIAL_THREAD = 0,
  parameter int BRANCH_COUNT = 4,
  parameter int SLOT_WIDTH = 2,
  parameter int DESTINATION_ADDR_OFFSET = 'h3C4,
  parameter int CONDITION_ADDR_OFFSET = 'h3C8,
  parameter int PREDICTION_ADDR_OFFSET = 'h3CC,
  parameter int PRED_ENABLE_ADDR_OFFSET = 'h3D0,
  parameter int ORIGIN_ADDR_OFFSET = 'h3C0
) (
  input logic clock,
  input logic reset_n,
  branch_entry_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;
  state_t state, state_next;
  logic [2:0] field;
  logic [THREAD_ADDR_WIDTH-1:0] thread, lat_thread;
  logic [SLOT_WIDTH-1:0] lat_slot;
  logic [PC_WIDTH-1:0] lat_origin, lat_dest;
  logic [COND_WIDTH-1:0] lat_cond;
  logic lat_pred, lat_pen;
  logic accept, issue;
  logic [D_OPERAND_WIDTH-1:0] base;
  logic [WORD_WIDTH-1:0] data;
  assign accept = state == IDLE && bus.req_valid;
  assign issue = state == WRITE && thread == lat_thread && !bus.alu_write_valid;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (accept) state_next = int'(bus.req_slot) >= BRANCH_COUNT ? ERR : WRITE;
    else if (state == WRITE) state_next = issue && field == 3'd4 ? DONE : WRITE;
    else if (state != IDLE) state_next = IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      thread <= THREAD_ADDR_WIDTH'(INITIAL_THREAD);
      field <= '0;
      lat_thread <= '0;
      lat_slot <= '0;
      lat_origin <= '0;
      lat_dest <= '0;
      lat_cond <= '0;
      lat_pred <= 1'b0;
      lat_pen <= 1'b0;
    end else begin
      thread <= thread == THREAD_ADDR_WIDTH'(THREAD_COUNT - 1) ? '0 : thread + 1'b1;
      field <= accept ? '0 : issue ? field + 3'd1 : field;
      if (accept) begin
        lat_thread <= bus.req_thread;
        lat_slot <= bus.req_slot;
        lat_origin <= bus.req_origin;
        lat_dest <= bus.req_destination;
        lat_cond <= bus.req_condition;
        lat_pred <= bus.req_prediction;
        lat_pen <= bus.req_pred_enable;
      end
    end
  // origin goes last so a half-built entry never matches a fetch PC
  always_comb begin
    base = field == 3'd0 ? D_OPERAND_WIDTH'(DESTINATION_ADDR_OFFSET) :
           field == 3'd1 ? D_OPERAND_WIDTH'(CONDITION_ADDR_OFFSET) :
           field == 3'd2 ? D_OPERAND_WIDTH'(PREDICTION_ADDR_OFFSET) :
           field == 3'd3 ? D_OPERAND_WIDTH'(PRED_ENABLE_ADDR_OFFSET) :
                           D_OPERAND_WIDTH'(ORIGIN_ADDR_OFFSET);
    data = field == 3'd0 ? WORD_WIDTH'(lat_dest) :
           field == 3'd1 ? WORD_WIDTH'(lat_cond) :
           field == 3'd2 ? WORD_WIDTH'(lat_pred) :
           field == 3'd3 ? WORD_WIDTH'(lat_pen) :
                           WORD_WIDTH'(lat_origin);
  end
  assign bus.wr_valid = issue;
  assign bus.wr_addr = issue ? base + D_OPERAND_WIDTH'(lat_slot) : '0;
  assign bus.wr_data = issue ? data : '0;
  assign bus.req_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.error = state == ERR;
  assign bus.current_thread = thread;
endmodule

// File: tb/tb_branch_entry_loader.sv
// tb_branch_entry_loader: directed and random installs checked every cycle against a queue-based model
module tb_branch_entry_loader;
  localparam int TC = 8;
  logic clock = 1'b0;
  logic reset_n;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_edge = 0, done_edge = -1, err_edge = -1;
  int m_mode = 0, m_thr = 0, m_lat = 0;
  logic [47:0] q[$];
  logic [47:0] log_q[$];
  branch_entry_loader_if #(.SLOT_WIDTH(3)) bus();
  branch_entry_loader #(.SLOT_WIDTH(3)) dut(.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic wv;
    logic [47:0] e;
    wv = m_mode == 1 && m_thr == m_lat && !bus.alu_write_valid;
    e = wv ? q[0] : 48'd0;
    check("req_ready", bus.req_ready, m_mode == 0);
    check("busy", bus.busy, m_mode != 0);
    check("done", bus.done, m_mode == 2);
    check("error", bus.error, m_mode == 3);
    check("current_thread", bus.current_thread, m_thr);
    check("wr_valid", bus.wr_valid, wv);
    check("wr_addr", bus.wr_addr, e[47:36]);
    check("wr_data", bus.wr_data, e[35:0]);
    if (bus.wr_valid) log_q.push_back({bus.wr_addr, bus.wr_data});
    if (bus.done) done_edge = cyc;
    if (bus.error) err_edge = cyc;
  endtask

  // entry rules: five writes in order dest, cond, pred, pen, origin; each waits for a free slot of the thread
  task automatic model_edge();
    logic wv;
    int s;
    wv = m_mode == 1 && m_thr == m_lat && !bus.alu_write_valid;
    if (!reset_n) begin
      m_mode = 0;
      m_thr = 0;
      q.delete();
    end else begin
      if (m_mode == 0 && bus.req_valid) begin
        acc_edge = cyc;
        s = int'(bus.req_slot);
        if (s >= 4) m_mode = 3;
        else begin
          m_lat = int'(bus.req_thread);
          q.delete();
          q.push_back({12'('h3C4 + s), 36'(bus.req_destination)});
          q.push_back({12'('h3C8 + s), 36'(bus.req_condition)});
          q.push_back({12'('h3CC + s), 36'(bus.req_prediction)});
          q.push_back({12'('h3D0 + s), 36'(bus.req_pred_enable)});
          q.push_back({12'('h3C0 + s), 36'(bus.req_origin)});
          m_mode = 1;
        end
      end else if (wv) begin
        void'(q.pop_front());
        if (q.size() == 0) m_mode = 2;
      end else if (m_mode >= 2) m_mode = 0;
      m_thr = (m_thr + 1) % TC;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_req(input int thr, input int slot, input int origin, input int dest,
                         input int cond, input int pred, input int pen);
    bus.req_valid = 1'b1;
    bus.req_thread = 3'(thr);
    bus.req_slot = 3'(slot);
    bus.req_origin = 10'(origin);
    bus.req_destination = 10'(dest);
    bus.req_condition = 8'(cond);
    bus.req_prediction = 1'(pred);
    bus.req_pred_enable = 1'(pen);
  endtask

  task automatic accept(input int thr, input int slot, input int origin, input int dest,
                        input int cond, input int pred, input int pen);
    set_req(thr, slot, origin, dest, cond, pred, pen);
    tick();
    bus.req_valid = 1'b0;
    log_q.delete();
    done_edge = -1;
    err_edge = -1;
  endtask

  task automatic wait_thr(input int t);
    for (int i = 0; i < TC && m_thr != t; i++) tick();
  endtask

  task automatic finish_install();
    for (int i = 0; i < 200 && m_mode != 0; i++) tick();
  endtask

  initial begin
    logic [11:0] addr_exp [5] = '{12'h3C5, 12'h3C9, 12'h3CD, 12'h3D1, 12'h3C1};
    logic [35:0] data_exp [5] = '{36'h013, 36'hFF, 36'h1, 36'h1, 36'h2A5};
    bus.alu_write_valid = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 check_outputs();
    @(posedge clock);
    #1 reset_n = 1'b1;
    wait_thr(7);
    accept(0, 1, 'h155, 'h0AA, 'h3C, 1, 0);
    finish_install();
    check("s1_done_latency", done_edge - acc_edge, 34);
    check("s1_write_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check("s1_addr", log_q[i][47:36], addr_exp[i]);
    wait_thr(7);
    accept(0, 1, 'h155, 'h0AA, 'h3C, 1, 0);
    tick();
    wait_thr(0);
    bus.alu_write_valid = 1'b1;
    tick();
    bus.alu_write_valid = 1'b0;
    finish_install();
    check("s2_done_latency", done_edge - acc_edge, 42);
    check("s2_write_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check("s2_addr", log_q[i][47:36], addr_exp[i]);
    accept(2, 5, 'h1, 'h2, 'h3, 1, 1);
    tick();
    tick();
    check("s3_error_latency", err_edge - acc_edge, 1);
    check("s3_write_count", log_q.size(), 0);
    set_req(6, 3, 'h3FF, 'h100, 'h81, 0, 1);
    for (int i = 0; i < 30; i++) begin
      tick();
      set_req($urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    bus.req_valid = 1'b0;
    finish_install();
    wait_thr(3);
    accept(5, 2, 'h2A5, 'h013, 'hFF, 1, 1);
    finish_install();
    check("s5_write_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check("s5_data", log_q[i][35:0], data_exp[i]);
    accept(3, 0, 'h111, 'h222, 'h33, 1, 0);
    for (int i = 0; i < 40 && q.size() > 3; i++) tick();
    #2 reset_n = 1'b0;
    #1;
    m_mode = 0;
    m_thr = 0;
    q.delete();
    check_outputs();
    tick();
    tick();
    reset_n = 1'b1;
    log_q.delete();
    for (int i = 0; i < 24; i++) tick();
    check("s6_no_write_after_reset", log_q.size(), 0);
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid = $urandom_range(0, 3) == 0;
      bus.req_thread = 3'($urandom);
      bus.req_slot = 3'($urandom_range(0, 5));
      bus.req_origin = 10'($urandom);
      bus.req_destination = 10'($urandom);
      bus.req_condition = 8'($urandom);
      bus.req_prediction = 1'($urandom);
      bus.req_pred_enable = 1'($urandom);
      bus.alu_write_valid = $urandom_range(0, 3) == 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
